// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for an asynchronous FIFO: the write pointer (binary and
// Gray), memory write strobe, and registered fill level / full / almost-full / overflow flags.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH     = 2,
  parameter int ALMOST_FULL_TH = 3
) (
  input  logic                  wr_clk,
  input  logic                  wr_reset_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   wr_level_o,
  output logic                  overflow_o
);

  localparam int            PW      = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_L = PW'(1 << ADDR_WIDTH);
  localparam logic [PW-1:0] AF_TH   = PW'(ALMOST_FULL_TH);

  logic [PW-1:0] r_wr_bin;
  logic [PW-1:0] r_wr_gray;
  logic [PW-1:0] r_level;
  logic          r_full;
  logic          r_afull;
  logic          r_ovf;

  logic          w_push;
  logic [PW-1:0] w_next_bin;
  logic [PW-1:0] w_rd_bin;
  logic [PW-1:0] w_next_level;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Push is gated by reset so the memory never sees a strobe during reset.
  assign w_push       = wr_en_i & ~r_full & wr_reset_n;
  assign w_next_bin   = r_wr_bin + {{(PW-1){1'b0}}, w_push};
  assign w_rd_bin     = gray2bin(rd_ptr_gray_sync_i);
  assign w_next_level = w_next_bin - w_rd_bin;

  always_ff @(posedge wr_clk) begin
    if (!wr_reset_n) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_bin  <= w_next_bin;
      r_wr_gray <= w_next_bin ^ (w_next_bin >> 1);
      r_level   <= w_next_level;
      r_full    <= (w_next_level == DEPTH_L);
      r_afull   <= (w_next_level >= AF_TH);
      if (wr_en_i && r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign mem_we_o      = w_push;
  assign wr_addr_o     = r_wr_bin[ADDR_WIDTH-1:0];
  assign wr_ptr_gray_o = r_wr_gray;
  assign full_o        = r_full;
  assign almost_full_o = r_afull;
  assign wr_level_o    = r_level;
  assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl (ADDR_WIDTH=2, ALMOST_FULL_TH=3): fill, overflow,
// read-side release, balanced push/pop across pointer wrap, and mid-stream reset.
module tb_fifo_wr_ctrl;

  logic       wr_clk;
  logic       wr_reset_n;
  logic       wr_en_i;
  logic [2:0] rd_ptr_gray_sync_i;
  logic       mem_we_o;
  logic [1:0] wr_addr_o;
  logic [2:0] wr_ptr_gray_o;
  logic       full_o;
  logic       almost_full_o;
  logic [2:0] wr_level_o;
  logic       overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_ctrl #(.ADDR_WIDTH(2), .ALMOST_FULL_TH(3)) dut (
    .wr_clk             (wr_clk),
    .wr_reset_n         (wr_reset_n),
    .wr_en_i            (wr_en_i),
    .rd_ptr_gray_sync_i (rd_ptr_gray_sync_i),
    .mem_we_o           (mem_we_o),
    .wr_addr_o          (wr_addr_o),
    .wr_ptr_gray_o      (wr_ptr_gray_o),
    .full_o             (full_o),
    .almost_full_o      (almost_full_o),
    .wr_level_o         (wr_level_o),
    .overflow_o         (overflow_o)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Gray codes of binary 0..7, written out by hand.
  logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                               3'b110, 3'b111, 3'b101, 3'b100};

  task automatic drive(input logic rst_n, input logic en, input logic [2:0] rdg);
    @(negedge wr_clk);
    wr_reset_n         = rst_n;
    wr_en_i            = en;
    rd_ptr_gray_sync_i = rdg;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    wr_reset_n         = 1'b0;
    wr_en_i            = 1'b0;
    rd_ptr_gray_sync_i = 3'b000;
    edge_wait();
    edge_wait();

    // Reset state, including strobe suppression with a write request held high.
    drive(1'b0, 1'b1, 3'b000);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    edge_wait();
    chk("rst_gray",  32'(wr_ptr_gray_o), 32'd0);
    chk("rst_level", 32'(wr_level_o), 32'd0);
    chk("rst_full",  32'(full_o), 32'd0);
    chk("rst_afull", 32'(almost_full_o), 32'd0);
    chk("rst_ovf",   32'(overflow_o), 32'd0);
    chk("rst_addr",  32'(wr_addr_o), 32'd0);

    drive(1'b1, 1'b0, 3'b000);
    edge_wait();
    chk("idle_level", 32'(wr_level_o), 32'd0);

    // Four writes fill the FIFO.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 3'b000);
      chk($sformatf("fill_addr%0d", k), 32'(wr_addr_o), 32'(k));
      chk($sformatf("fill_we%0d", k),   32'(mem_we_o), 32'd1);
      edge_wait();
      chk($sformatf("fill_gray%0d", k),  32'(wr_ptr_gray_o), 32'(gray_tab[k+1]));
      chk($sformatf("fill_level%0d", k), 32'(wr_level_o), 32'(k + 1));
      chk($sformatf("fill_afull%0d", k), 32'(almost_full_o), (k >= 2) ? 32'd1 : 32'd0);
      chk($sformatf("fill_full%0d", k),  32'(full_o), (k == 3) ? 32'd1 : 32'd0);
    end

    // Write while full is dropped and flags overflow, which then sticks.
    drive(1'b1, 1'b1, 3'b000);
    chk("ovf_we", 32'(mem_we_o), 32'd0);
    chk("ovf_before", 32'(overflow_o), 32'd0);
    edge_wait();
    chk("ovf_gray",  32'(wr_ptr_gray_o), 32'b110);
    chk("ovf_level", 32'(wr_level_o), 32'd4);
    chk("ovf_set",   32'(overflow_o), 32'd1);
    drive(1'b1, 1'b0, 3'b000);
    edge_wait();
    chk("ovf_hold", 32'(overflow_o), 32'd1);

    // Read pointer advances by one: level 3, no longer full, still almost full.
    drive(1'b1, 1'b0, 3'b001);
    chk("rdadv_full_pre", 32'(full_o), 32'd1);
    edge_wait();
    chk("rdadv_full",  32'(full_o), 32'd0);
    chk("rdadv_level", 32'(wr_level_o), 32'd3);
    chk("rdadv_afull", 32'(almost_full_o), 32'd1);

    // Push together with a read advance keeps level at 3.
    drive(1'b1, 1'b1, 3'b011);
    chk("bal_addr", 32'(wr_addr_o), 32'd0);
    chk("bal_we",   32'(mem_we_o), 32'd1);
    edge_wait();
    chk("bal_level", 32'(wr_level_o), 32'd3);
    chk("bal_full",  32'(full_o), 32'd0);
    chk("bal_gray",  32'(wr_ptr_gray_o), 32'b111);

    // Nine more balanced pushes, crossing the pointer wrap 7 -> 0.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, gray_tab[(3 + i) % 8]);
      chk($sformatf("wrap_addr%0d", i), 32'(wr_addr_o), 32'((5 + i) % 4));
      chk($sformatf("wrap_we%0d", i),   32'(mem_we_o), 32'd1);
      edge_wait();
      chk($sformatf("wrap_gray%0d", i),  32'(wr_ptr_gray_o), 32'(gray_tab[(6 + i) % 8]));
      chk($sformatf("wrap_level%0d", i), 32'(wr_level_o), 32'd3);
      chk($sformatf("wrap_full%0d", i),  32'(full_o), 32'd0);
    end

    // Mid-stream reset with a write request: strobe suppressed, everything clears.
    drive(1'b0, 1'b1, gray_tab[3]);
    chk("mrst_we", 32'(mem_we_o), 32'd0);
    edge_wait();
    chk("mrst_gray",  32'(wr_ptr_gray_o), 32'd0);
    chk("mrst_addr",  32'(wr_addr_o), 32'd0);
    chk("mrst_level", 32'(wr_level_o), 32'd0);
    chk("mrst_full",  32'(full_o), 32'd0);
    chk("mrst_afull", 32'(almost_full_o), 32'd0);
    chk("mrst_ovf",   32'(overflow_o), 32'd0);

    // Restart cleanly from address 0.
    drive(1'b1, 1'b1, 3'b000);
    chk("restart_addr", 32'(wr_addr_o), 32'd0);
    chk("restart_we",   32'(mem_we_o), 32'd1);
    edge_wait();
    chk("restart_gray",  32'(wr_ptr_gray_o), 32'b001);
    chk("restart_level", 32'(wr_level_o), 32'd1);

    drive(1'b1, 1'b0, 3'b000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
